addsub_arbiter: RTL and testbench

//  Shares one 8-bit adder_subtractor instance between NREQ requesters. Round-robin

---
 rtl/addsub_pkg.sv | 12 +
 rtl/adder_subtractor.sv | 24 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/addsub_arbiter.sv | 141 ++++++++++++++
 tb/tb_addsub_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the arbitrated add/sub datapath.
package addsub_pkg;
  localparam int DATA_W = 8;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/adder_subtractor.sv
// Combinational 8-bit add/subtract with two's-complement overflow flag.
module adder_subtractor
  import addsub_pkg::*;
(
  input  logic              en_i,
  input  logic              op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] s_o,
  output logic              ovf_o
);
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W-1:0] low_sum;
  logic [DATA_W:0]   full_sum;

  // Subtraction is a + ~b + 1; low_sum[MSB] is the carry into the sign bit.
  assign b_eff    = (op_i == OP_SUB) ? ~b_i : b_i;
  assign low_sum  = {1'b0, a_i[DATA_W-2:0]} + {1'b0, b_eff[DATA_W-2:0]}
                    + {{(DATA_W-1){1'b0}}, op_i};
  assign full_sum = {1'b0, a_i} + {1'b0, b_eff} + {{DATA_W{1'b0}}, op_i};

  assign s_o   = en_i ? full_sum[DATA_W-1:0] : '0;
  assign ovf_o = en_i & (low_sum[DATA_W-1] ^ full_sum[DATA_W]);
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr_i, wrapping at NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [ID_W-1:0] idx_o,
  output logic            any_o
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  int            cand;
  logic [IW-1:0] cand_ix;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = 0;
    cand_ix = '0;
    for (int k = 1; k <= NREQ; k++) begin
      // ptr_i < NREQ, so one conditional subtract is enough to wrap.
      cand = int'(ptr_i) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_ix = IW'(cand);
      if (!any_o && req_i[cand_ix]) begin
        any_o            = 1'b1;
        grant_o[cand_ix] = 1'b1;
        idx_o            = ID_W'(cand_ix);
      end
    end
  end
endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin front end sharing one adder_subtractor among NREQ requesters,
// one operation in flight, tagged response.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*8-1:0]    req_a,
  input  logic [NREQ*8-1:0]    req_b,
  input  logic [NREQ-1:0]      req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_s,
  output logic                 rsp_ovf,
  output logic [ID_W-1:0]      rsp_id,
  output logic [1:0]           dbg_state_o
);
  // Handshakes: a request transfers in the cycle req_valid[i] && req_ready[i]
  // (only in IDLE); a response transfers in the cycle rsp_valid && rsp_ready,
  // and rsp_s/rsp_ovf/rsp_id hold steady while rsp_valid waits for rsp_ready.
  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              op_q, op_d;
  logic [DATA_W-1:0] rsp_s_q, rsp_s_d;
  logic              rsp_ovf_q, rsp_ovf_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;

  logic [NREQ-1:0]   grant;
  logic [ID_W-1:0]   grant_idx;
  logic              any_req;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic              sel_op;
  logic              alu_en;
  logic [DATA_W-1:0] alu_s;
  logic              alu_ovf;

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (any_req)
  );

  adder_subtractor u_alu (
    .en_i  (alu_en),
    .op_i  (op_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .s_o   (alu_s),
    .ovf_o (alu_ovf)
  );

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = OP_ADD;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a  = req_a[i*8 +: 8];
        sel_b  = req_b[i*8 +: 8];
        sel_op = req_op[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    rsp_s_d   = rsp_s_q;
    rsp_ovf_d = rsp_ovf_q;
    rsp_id_d  = rsp_id_q;
    alu_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          ptr_d   = grant_idx;
          id_d    = grant_idx;
          a_d     = sel_a;
          b_d     = sel_b;
          op_d    = sel_op;
          state_d = CALC;
        end
      end
      CALC: begin
        alu_en    = 1'b1;
        rsp_s_d   = alu_s;
        rsp_ovf_d = alu_ovf;
        rsp_id_d  = id_q;
        state_d   = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= ID_W'(NREQ - 1);
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_ADD;
      rsp_s_q   <= '0;
      rsp_ovf_q <= 1'b0;
      rsp_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      rsp_s_q   <= rsp_s_d;
      rsp_ovf_q <= rsp_ovf_d;
      rsp_id_q  <= rsp_id_d;
    end
  end

  // Masked by rst_n so no accept pulse can escape while reset is held.
  assign req_ready   = (state_q == IDLE && rst_n) ? grant : '0;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_s       = rsp_s_q;
  assign rsp_ovf     = rsp_ovf_q;
  assign rsp_id      = rsp_id_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: arithmetic, round-robin order, backpressure, reset abort.
module tb_addsub_arbiter;
  import addsub_pkg::*;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ-1:0]   req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_s;
  logic              rsp_ovf;
  logic [ID_W-1:0]   rsp_id;
  logic [1:0]        dbg_state;

  int checks;
  int errors;

  logic [7:0] rr_exp_s [4];

  addsub_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_s       (rsp_s),
    .rsp_ovf     (rsp_ovf),
    .rsp_id      (rsp_id),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic set_req(input int i, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic op);
    req_valid[i]     = v;
    req_a[i*8 +: 8]  = a;
    req_b[i*8 +: 8]  = b;
    req_op[i]        = op;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    step();
    set_req(0, 1'b1, 8'h01, 8'h02, OP_ADD);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_s !== 8'h00) begin errors++; $display("FAIL reset_s: got %h want 00", rsp_s); end
    checks++; if (rsp_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", rsp_ovf); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
    checks++; if (dbg_state !== 2'(IDLE)) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, 2'(IDLE)); end
    set_req(0, 1'b0, 8'h00, 8'h00, OP_ADD);
    step();
    rst_n = 1'b1;
    step();
  endtask

  // 0x7F + 0x01: signed overflow, response two cycles after accept.
  task automatic test_add_ovf();
    set_req(0, 1'b1, 8'h7F, 8'h01, OP_ADD);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL add_grant: got %b want 0001", req_ready); end
    step();
    set_req(0, 1'b0, 8'h00, 8'h00, OP_ADD);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_lat1: got %b want 0", rsp_valid); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL add_calc_ready: got %b want 0000", req_ready); end
    step();
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_lat2: got %b want 1", rsp_valid); end
    checks++; if (rsp_s !== 8'h80) begin errors++; $display("FAIL add_s: got %h want 80", rsp_s); end
    checks++; if (rsp_ovf !== 1'b1) begin errors++; $display("FAIL add_ovf: got %b want 1", rsp_ovf); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL add_id: got %0d want 0", rsp_id); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_done: got %b want 0", rsp_valid); end
  endtask

  // Two subtracts from requester 1, the second granted with ptr already at 1.
  task automatic test_sub();
    logic [7:0] av [2];
    logic [7:0] bv [2];
    logic [7:0] sv [2];
    logic       ov [2];
    av = '{8'h80, 8'h05};
    bv = '{8'h01, 8'h07};
    sv = '{8'h7F, 8'hFE};
    ov = '{1'b1, 1'b0};
    for (int n = 0; n < 2; n++) begin
      set_req(1, 1'b1, av[n], bv[n], OP_SUB);
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL sub%0d_grant: got %b want 0010", n, req_ready); end
      step();
      set_req(1, 1'b0, 8'h00, 8'h00, OP_ADD);
      step();
      #1;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL sub%0d_valid: got %b want 1", n, rsp_valid); end
      checks++; if (rsp_s !== sv[n]) begin errors++; $display("FAIL sub%0d_s: got %h want %h", n, rsp_s, sv[n]); end
      checks++; if (rsp_ovf !== ov[n]) begin errors++; $display("FAIL sub%0d_ovf: got %b want %b", n, rsp_ovf, ov[n]); end
      checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL sub%0d_id: got %0d want 1", n, rsp_id); end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
    end
  endtask

  // All requesters held valid from reset: grants 0,1,2,3,0 every third cycle.
  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    int         g;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rr_exp_s = '{8'h11, 8'h1E, 8'h33, 8'h3C};
    for (int i = 0; i < NREQ; i++)
      set_req(i, 1'b1, 8'((i + 1) * 16), 8'(i + 1), 1'(i % 2));
    rsp_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      #1;
      g       = (c / 3) % 4;
      exp_rdy = (c % 3 == 0) ? (4'b0001 << g) : 4'b0000;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready c%0d: got %b want %b", c, req_ready, exp_rdy); end
      checks++; if (rsp_valid !== (c % 3 == 2)) begin errors++; $display("FAIL rr_valid c%0d: got %b want %b", c, rsp_valid, (c % 3 == 2)); end
      if (c % 3 == 2) begin
        checks++; if (rsp_id !== 2'(g)) begin errors++; $display("FAIL rr_id c%0d: got %0d want %0d", c, rsp_id, g); end
        checks++; if (rsp_s !== rr_exp_s[g]) begin errors++; $display("FAIL rr_s c%0d: got %h want %h", c, rsp_s, rr_exp_s[g]); end
        checks++; if (rsp_ovf !== 1'b0) begin errors++; $display("FAIL rr_ovf c%0d: got %b want 0", c, rsp_ovf); end
      end
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b0;
  endtask

  // Response held under backpressure; next pending request granted right after release.
  task automatic test_backpressure();
    set_req(2, 1'b1, 8'h7F, 8'h80, OP_SUB);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant: got %b want 0100", req_ready); end
    step();
    set_req(2, 1'b0, 8'h00, 8'h00, OP_ADD);
    set_req(3, 1'b1, 8'h01, 8'h01, OP_ADD);
    step();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d: got %b want 1", c, rsp_valid); end
      checks++; if (rsp_s !== 8'hFF) begin errors++; $display("FAIL bp_s c%0d: got %h want ff", c, rsp_s); end
      checks++; if (rsp_ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf c%0d: got %b want 1", c, rsp_ovf); end
      checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL bp_id c%0d: got %0d want 2", c, rsp_id); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready c%0d: got %b want 0000", c, req_ready); end
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b want 0", rsp_valid); end
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_next_grant: got %b want 1000", req_ready); end
    step();
    set_req(3, 1'b0, 8'h00, 8'h00, OP_ADD);
    step();
    #1;
    checks++; if (rsp_s !== 8'h02) begin errors++; $display("FAIL bp_next_s: got %h want 02", rsp_s); end
    checks++; if (rsp_id !== 2'd3) begin errors++; $display("FAIL bp_next_id: got %0d want 3", rsp_id); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  // Reset asserted while an op is in CALC: op dropped, requester 0 first after release.
  task automatic test_reset_mid_op();
    set_req(1, 1'b1, 8'h11, 8'h22, OP_ADD);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rst_pre_grant: got %b want 0010", req_ready); end
    step();
    set_req(1, 1'b0, 8'h00, 8'h00, OP_ADD);
    set_req(0, 1'b1, 8'h40, 8'h40, OP_ADD);
    set_req(2, 1'b1, 8'hFF, 8'h01, OP_ADD);
    #1;
    checks++; if (dbg_state !== 2'(CALC)) begin errors++; $display("FAIL rst_in_calc: got %0d want %0d", dbg_state, 2'(CALC)); end
    rst_n = 1'b0;
    #1;
    checks++; if (dbg_state !== 2'(IDLE)) begin errors++; $display("FAIL rst_state: got %0d want %0d", dbg_state, 2'(IDLE)); end
    checks++; if (rsp_s !== 8'h00) begin errors++; $display("FAIL rst_s: got %h want 00", rsp_s); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL rst_id: got %0d want 0", rsp_id); end
    for (int c = 0; c < 2; c++) begin
      step();
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_valid c%0d: got %b want 0", c, rsp_valid); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_hold_ready c%0d: got %b want 0000", c, req_ready); end
    end
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_after_grant: got %b want 0001", req_ready); end
    step();
    set_req(0, 1'b0, 8'h00, 8'h00, OP_ADD);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_no_stale: got %b want 0", rsp_valid); end
    step();
    #1;
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL rst_new_id: got %0d want 0", rsp_id); end
    checks++; if (rsp_s !== 8'h80) begin errors++; $display("FAIL rst_new_s: got %h want 80", rsp_s); end
    checks++; if (rsp_ovf !== 1'b1) begin errors++; $display("FAIL rst_new_ovf: got %b want 1", rsp_ovf); end
    rsp_ready = 1'b1;
    step();
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rst_req2_grant: got %b want 0100", req_ready); end
    step();
    set_req(2, 1'b0, 8'h00, 8'h00, OP_ADD);
    step();
    #1;
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL rst_req2_id: got %0d want 2", rsp_id); end
    checks++; if (rsp_s !== 8'h00) begin errors++; $display("FAIL rst_req2_s: got %h want 00", rsp_s); end
    checks++; if (rsp_ovf !== 1'b0) begin errors++; $display("FAIL rst_req2_ovf: got %b want 0", rsp_ovf); end
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add_ovf();
    test_sub();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
